mul_operand_feeder: RTL and testbench
=====================================

Name: mul_operand_feeder

Overview:
- Upstream issue stage for the 8-bit shift-add multiplier datapath and its Moore control FSM.
- Buffers operand pairs (multiplicand B, multiplier Q) from a producer in a small FIFO.
- Presents one pair at a time to the multiplier, pulses its start input and tracks its 3-bit state code until READY.
- Captures the 17-bit product and returns it to the consumer with a valid/ready handshake.

Parameters:
- BITS, 8, operand width; the product width is 2*BITS+1.
- DEPTH, 4, operand FIFO entries; must be a power of 2, minimum 2.
- TIMEOUT, 64, maximum cycles spent in WAIT_BUSY or WAIT_DONE before an error is flagged.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer offers an operand pair.
- in_ready  out  1  FIFO not full.
- in_b  in  BITS  multiplicand.
- in_q  in  BITS  multiplier.
- mul_b  out  BITS  multiplicand driven to the multiplier (DP_B side).
- mul_q  out  BITS  multiplier operand driven to the multiplier (DP_Q side).
- mul_start  out  1  one-cycle start pulse to the multiplier control FSM.
- mul_state  in  3  multiplier state code: LOAD=000, SHIFT=001, ADD=010, DECR=011, READY=100.
- mul_product  in  2*BITS+1  multiplier product.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_product  out  2*BITS+1  captured product.
- err_timeout  out  1  sticky timeout flag.

Behaviour:
- Reset (asynchronous, active-high) values: FIFO empty, FSM in IDLE, in_ready=1, mul_start=0, mul_b=0, mul_q=0, out_valid=0, out_product=0, err_timeout=0, watchdog=0.
- FIFO push: on in_valid && in_ready.
- FIFO pop: on the IDLE->ISSUE transition only.
- Push and pop in the same cycle are both allowed, including when the FIFO is full; pop frees the slot first, so in_ready = !full || pop_this_cycle.
- FIFO pointers wrap modulo DEPTH. The occupancy counter is log2(DEPTH)+1 bits wide.
- State IDLE: if the FIFO is not empty, pop the head into mul_b/mul_q and go to ISSUE.
- State ISSUE: mul_start=1 for exactly one cycle; go to WAIT_BUSY. mul_b/mul_q stay stable from ISSUE until the product is captured.
- State WAIT_BUSY: wait for mul_state != LOAD; then go to WAIT_DONE.
- State WAIT_DONE: wait for mul_state == READY. On READY, register out_product <= mul_product, set out_valid=1, go to HOLD.
  - A READY code seen directly in WAIT_BUSY counts as busy and done together: capture and go to HOLD.
- State HOLD: keep out_valid and out_product stable until out_ready. On out_valid && out_ready, clear out_valid and go to IDLE.
  - The next pop happens in the following cycle, so back-to-back issues are spaced by at least one IDLE cycle.
- Issue latency: the first pair pushed into an empty FIFO reaches mul_start two cycles after the push.
- Watchdog: resets on entry to WAIT_BUSY and counts each cycle spent in WAIT_BUSY/WAIT_DONE.
  - When the count reaches TIMEOUT: set err_timeout (sticky until rst), drop the transaction without asserting out_valid, return to IDLE.
- Reset mid-operation: the FSM aborts, the FIFO is flushed and any in-flight product is discarded.
- out_valid never rises while in_valid or other inputs change. Only the HOLD handshake clears it.

Optional Feature:
- Macro FEEDER_STATS_EN.
- When defined: adds outputs done_count[15:0] and timeout_count[7:0].
  - done_count increments on each out_valid && out_ready; timeout_count increments on each timeout.
  - Both saturate at all-ones and reset to 0.
- When undefined: neither port nor its counters exist, and behaviour is otherwise identical.

Test Plan:
- Single op: push B=8'd13, Q=8'd11; model the multiplier as LOAD, then SHIFT/ADD/DECR for 8 cycles, then READY with product 143 -> mul_start pulses once, 2 cycles after the push; out_product=17'd143, out_valid held until out_ready.
- Fill/overflow: push 5 pairs with out_ready=0 and DEPTH=4 -> in_ready falls after the 4th push in the FIFO plus one in flight; no pair lost; results come out in order (3*5=15, 7*9=63, 255*255=65025, ...).
- Simultaneous push/pop with the FIFO full -> in_ready=1 in the pop cycle; occupancy unchanged.
- Backpressure: hold out_ready=0 for 20 cycles -> out_product stable, no new mul_start; one cycle after out_ready=1, the next pair is popped.
- Timeout: mul_state stuck at LOAD after start -> err_timeout=1 after 64 cycles, no out_valid, FIFO continues with the next pair.
- Reset mid-WAIT_DONE: assert rst asynchronously -> all outputs return to reset values immediately, FIFO empty, in_ready=1.

Source files
------------

// File: rtl/mul_operand_feeder.sv
// rtl/mul_operand_feeder.sv - operand FIFO and issue/capture sequencer for the shift-add multiplier
// Optional macro FEEDER_STATS_EN adds the done_count/timeout_count outputs.
module mul_operand_feeder #(
  parameter int BITS    = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BITS-1:0]   in_b,
  input  logic [BITS-1:0]   in_q,
  output logic [BITS-1:0]   mul_b,
  output logic [BITS-1:0]   mul_q,
  output logic              mul_start,
  input  logic [2:0]        mul_state,
  input  logic [2*BITS:0]   mul_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*BITS:0]   out_product,
  output logic              err_timeout
`ifdef FEEDER_STATS_EN
  ,
  output logic [15:0]       done_count,
  output logic [7:0]        timeout_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [2:0] MS_LOAD  = 3'b000;
  localparam logic [2:0] MS_READY = 3'b100;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HOLD} state_t;
  state_t state, state_nxt;

  logic [2*BITS-1:0] fifo_mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [WW-1:0]     wd;
  logic              push, pop, full, waiting, capture, expire;

  // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
  assign full     = count == CW'(DEPTH);
  assign pop      = (state == IDLE) && (count != '0);
  assign in_ready = !full || pop;
  assign push     = in_valid && in_ready;
  assign waiting  = (state == WAIT_BUSY) || (state == WAIT_DONE);
  assign capture  = waiting && (mul_state == MS_READY);
  assign expire   = waiting && !capture && (wd == WW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {in_b, in_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // READY seen while still in WAIT_BUSY is treated as busy and done together.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (pop) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (capture)                    state_nxt = HOLD;
        else if (expire)                state_nxt = IDLE;
        else if (mul_state != MS_LOAD)  state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (capture)     state_nxt = HOLD;
        else if (expire) state_nxt = IDLE;
      end
      HOLD:      if (out_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mul_start = (state == ISSUE);
    out_valid = (state == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_b       <= '0;
      mul_q       <= '0;
      out_product <= '0;
      err_timeout <= 1'b0;
      wd          <= '0;
    end else begin
      if (pop)     {mul_b, mul_q} <= fifo_mem[rd_ptr];
      if (capture) out_product <= mul_product;
      if (expire)  err_timeout <= 1'b1;
      if (state == ISSUE) wd <= '0;
      else if (waiting)   wd <= wd + WW'(1);
    end
  end

`ifdef FEEDER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_count    <= '0;
      timeout_count <= '0;
    end else begin
      if (out_valid && out_ready && done_count != '1) done_count <= done_count + 16'd1;
      if (expire && timeout_count != '1)              timeout_count <= timeout_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_operand_feeder.sv
// tb/tb_mul_operand_feeder.sv - self-checking bench for mul_operand_feeder
// Pairs and expected products are tracked in queues; the multiplier is a small behavioural model.
module tb_mul_operand_feeder;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [7:0]  in_b, in_q, mul_b, mul_q;
  logic        mul_start;
  logic [2:0]  mul_state;
  logic [16:0] mul_product, out_product;
  logic        out_valid, out_ready, err_timeout;
`ifdef FEEDER_STATS_EN
  logic [15:0] done_count;
  logic [7:0]  timeout_count;
`endif

  mul_operand_feeder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_b(in_b), .in_q(in_q), .mul_b(mul_b), .mul_q(mul_q),
    .mul_start(mul_start), .mul_state(mul_state), .mul_product(mul_product),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .err_timeout(err_timeout)
`ifdef FEEDER_STATS_EN
    , .done_count(done_count), .timeout_count(timeout_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [15:0] pq[$];
  logic [16:0] rq[$];
  int   starts = 0;
  int   busy_len = 8;
  int   left = 0;
  bit   stuck = 0, stuck_next = 0, load_hold = 0;
  logic [16:0] m_prod = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge after inputs are set: books the handshakes of the coming edge,
  // then advances one cycle and steps the multiplier model.
  task automatic tick();
    logic [15:0] pr;
    int eb, eq;
    if (!rst && in_valid && in_ready) pq.push_back({in_b, in_q});
    if (!rst && out_valid && out_ready) begin
      check("result_expected", 32'(rq.size() != 0), 1);
      if (rq.size() != 0) check("out_product", out_product, rq.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
    if (mul_start) begin
      starts++;
      check("pair_expected", 32'(pq.size() != 0), 1);
      if (pq.size() != 0) begin
        pr = pq.pop_front();
        check("mul_b", mul_b, pr[15:8]);
        check("mul_q", mul_q, pr[7:0]);
        eb = pr[15:8];
        eq = pr[7:0];
        if (stuck_next) begin
          stuck = 1; stuck_next = 0;
        end else begin
          stuck = 0;
          rq.push_back(17'(eb * eq));
        end
      end
      m_prod = 17'(mul_b) * 17'(mul_q);
      mul_state = 3'b000;
      left = busy_len;
      load_hold = 1;
    end else if (load_hold) begin
      load_hold = 0;
    end else if (!stuck && mul_state != 3'b100) begin
      if (left > 0) begin
        mul_state = (left % 3 == 0) ? 3'b011 : (left % 3 == 1) ? 3'b001 : 3'b010;
        mul_product = 17'($urandom);
        left--;
      end else begin
        mul_state = 3'b100;
        mul_product = m_prod;
      end
    end
  endtask

  task automatic push(input logic [7:0] b, input logic [7:0] q);
    int n = 0;
    in_valid = 1; in_b = b; in_q = q;
    while (!in_ready && n < 300) begin tick(); n++; end
    check("push_accept", in_ready, 1);
    tick();
    in_valid = 0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    out_ready = 1;
    while ((pq.size() != 0 || rq.size() != 0 || out_valid) && n < 2000) begin tick(); n++; end
    check(tag, 32'(pq.size() + rq.size()), 0);
    out_ready = 0;
  endtask

  initial begin
    int n, s;
    logic [16:0] held;
    bit seen_valid;
    rst = 1; in_valid = 0; in_b = 0; in_q = 0; out_ready = 0;
    mul_state = 3'b100; mul_product = '0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_b", mul_b, 0);
    check("rst_mul_q", mul_q, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_product", out_product, 0);
    check("rst_err", err_timeout, 0);
    rst = 0;
    tick();

    // single operation, 8 busy cycles
    busy_len = 8;
    s = starts;
    in_valid = 1; in_b = 8'd13; in_q = 8'd11;
    tick();
    in_valid = 0;
    check("lat_cycle1", mul_start, 0);
    tick();
    check("lat_cycle2", mul_start, 1);
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    check("single_valid", out_valid, 1);
    check("single_product", out_product, 143);
    check("single_start_once", starts - s, 1);
    repeat (3) tick();
    check("single_hold_valid", out_valid, 1);
    check("single_hold_product", out_product, 143);
    out_ready = 1;
    tick();
    out_ready = 0;
    check("single_release", out_valid, 0);

    // fill with one in flight, READY seen directly in WAIT_BUSY
    busy_len = 0;
    push(8'd3, 8'd5); push(8'd7, 8'd9); push(8'd255, 8'd255);
    push(8'($urandom), 8'($urandom)); push(8'($urandom), 8'($urandom));
    check("full_in_ready", in_ready, 0);
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    check("fill_first_product", out_product, 15);
    s = starts;
    held = out_product;
    repeat (20) begin
      tick();
      check("bp_product_stable", out_product, held);
      check("bp_valid", out_valid, 1);
      check("bp_no_start", starts - s, 0);
    end
    check("bp_in_ready", in_ready, 0);

    // release with a push pending on a full FIFO
    in_valid = 1; in_b = 8'h21; in_q = 8'h42;
    out_ready = 1;
    tick();
    out_ready = 0;
    check("pop_cycle_in_ready", in_ready, 1);
    check("pop_cycle_valid", out_valid, 0);
    tick();
    in_valid = 0;
    check("next_pop_start", mul_start, 1);
    check("still_full", in_ready, 0);
    drain("fill_drain");

    // timeout with multiplier stuck in LOAD
    busy_len = 3;
    stuck_next = 1;
    s = starts;
    push(8'h12, 8'h34); push(8'h05, 8'h06);
    n = 0;
    while (starts == s && n < 50) begin tick(); n++; end
    seen_valid = 0;
    repeat (64) begin tick(); seen_valid |= out_valid; end
    check("timeout_not_yet", err_timeout, 0);
    tick();
    check("timeout_flag", err_timeout, 1);
    check("timeout_no_valid", seen_valid | out_valid, 0);
    drain("timeout_drain");
    check("timeout_sticky", err_timeout, 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_b      = 8'($urandom);
      in_q      = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      busy_len  = $urandom_range(0, 9);
      if ($urandom_range(0, 200) == 0) stuck_next = 1;
      tick();
    end
    in_valid = 0;
    drain("random_drain");

    // reset while the multiplier is mid-operation and the FIFO is full
    busy_len = 20;
    stuck_next = 0;
    for (int i = 0; i < 5; i++) push(8'($urandom), 8'($urandom));
    repeat (2) tick();
    check("pre_reset_full", in_ready, 0);
    #2 rst = 1;
    #1;
    check("ar_in_ready", in_ready, 1);
    check("ar_mul_start", mul_start, 0);
    check("ar_mul_b", mul_b, 0);
    check("ar_mul_q", mul_q, 0);
    check("ar_out_valid", out_valid, 0);
    check("ar_out_product", out_product, 0);
    check("ar_err", err_timeout, 0);
    pq.delete(); rq.delete();
    mul_state = 3'b100; stuck = 0; load_hold = 0; left = 0;
    tick();
    rst = 0;
    s = starts;
    repeat (10) tick();
    check("flushed_no_start", starts - s, 0);
    check("flushed_in_ready", in_ready, 1);
    busy_len = 2;
    push(8'd6, 8'd7);
    drain("post_reset_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
